// File: rtl/parallel_in_serial_out_8_bits_if.sv
// parallel_in_serial_out_8_bits_if: load/data inputs and serial/register outputs of the PISO shifter
interface parallel_in_serial_out_8_bits_if #(
    parameter int WIDTH = 8
);
    logic             Load_Shiftb_In;
    logic [WIDTH-1:0] Parallel_Data_In;
    logic             Serial_Data_Out;
    logic [WIDTH-1:0] PISO_Shift_Register;

    modport master (
        output Load_Shiftb_In,
        output Parallel_Data_In,
        input  Serial_Data_Out,
        input  PISO_Shift_Register
    );

    modport slave (
        input  Load_Shiftb_In,
        input  Parallel_Data_In,
        output Serial_Data_Out,
        output PISO_Shift_Register
    );
endinterface

// File: rtl/parallel_in_serial_out_8_bits.sv
// parallel_in_serial_out_8_bits: loads a parallel word and shifts it out one bit per clock
module parallel_in_serial_out_8_bits #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL_BIT  = 1'b0
) (
    input logic                              Clk_In,
    input logic                              Reset_In,
    parallel_in_serial_out_8_bits_if.slave   piso
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    // Load takes priority over shift; the vacated end is filled with FILL_BIT
    always_comb begin
        r_d = MSB_FIRST ? {r_q[WIDTH-2:0], FILL_BIT} : {FILL_BIT, r_q[WIDTH-1:1]};
        r_d = piso.Load_Shiftb_In ? piso.Parallel_Data_In : r_d;
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) r_q <= '0;
        else           r_q <= r_d;
    end

    assign piso.PISO_Shift_Register = r_q;
    assign piso.Serial_Data_Out     = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];
endmodule

// File: tb/tb_parallel_in_serial_out_8_bits.sv
// tb_parallel_in_serial_out_8_bits: directed plan plus random load/shift/reset against an arithmetic model
module tb_parallel_in_serial_out_8_bits;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   model;

    parallel_in_serial_out_8_bits_if #(.WIDTH(8)) pif ();

    parallel_in_serial_out_8_bits dut (
        .Clk_In   (clk),
        .Reset_In (rst_n),
        .piso     (pif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_reg"}, int'(pif.PISO_Shift_Register), model);
        chk({tag, "_ser"}, int'(pif.Serial_Data_Out), model / 128);
    endtask

    // Called at a falling edge; applies one rising edge and checks at the next falling edge
    task automatic step(input logic load, input logic [7:0] data, input string tag);
        pif.Load_Shiftb_In   = load;
        pif.Parallel_Data_In = data;
        @(posedge clk);
        if (rst_n) model = load ? int'(data) : (model * 2) % 256;
        else       model = 0;
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Drops reset between edges, checks immediate clear, holds across an edge with load=1
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 model = 0;
        check_outputs({tag, "_async"});
        pif.Load_Shiftb_In   = 1'b1;
        pif.Parallel_Data_In = 8'hFF;
        @(negedge clk);
        check_outputs({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        int ser_seq [8];
        rst_n = 1'b0;
        model = 0;
        pif.Load_Shiftb_In   = 1'b1;
        pif.Parallel_Data_In = 8'hFF;
        #1 check_outputs("rst0");
        repeat (2) begin
            @(negedge clk);
            check_outputs("rst");
        end
        rst_n = 1'b1;

        ser_seq = '{0, 0, 1, 0, 0, 1, 0, 0};
        step(1'b1, 8'h24, "ld24");
        chk("ld24_ser_lit", int'(pif.Serial_Data_Out), ser_seq[0]);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 8'hFF, "sh24");
            chk("sh24_ser_lit", int'(pif.Serial_Data_Out), ser_seq[i]);
        end
        repeat (3) step(1'b0, 8'hFF, "sh24_tail");

        step(1'b1, 8'h81, "ld81");
        repeat (8) step(1'b0, 8'h00, "sh81");
        chk("sh81_end_lit", int'(pif.PISO_Shift_Register), 0);

        step(1'b1, 8'hF0, "ldF0");
        repeat (3) step(1'b0, 8'h00, "shF0");
        step(1'b1, 8'h0F, "reload");
        chk("reload_lit", int'(pif.PISO_Shift_Register), 8'h0F);
        step(1'b0, 8'h00, "sh0F");

        step(1'b1, 8'hAA, "ldAA");
        repeat (2) step(1'b0, 8'h00, "shAA");
        async_reset("midshift");
        repeat (3) step(1'b0, 8'h00, "post_rst");

        for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 8'h80 : 8'h00, "cont");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) async_reset("rand");
            else step($urandom_range(0, 5) == 0, 8'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
